// File: rtl/debug_pkg.sv
// Shared debug-path definitions: dump FSM state encoding and byte/word geometry.
// CKSUM state exists only when MEM_DUMP_CHECKSUM_EN is defined.
package debug_pkg;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_LATCH,
    ST_SEND,
`ifdef MEM_DUMP_CHECKSUM_EN
    ST_CKSUM,
`endif
    ST_FINISH
  } dump_state_e;
endpackage

// File: rtl/word_serializer.sv
// Holds one word and presents it MSB byte first; the sequencer owns the byte
// counter and advances the shift on each accepted transfer.
module word_serializer
  import debug_pkg::*;
#(
  parameter int WORD_W = BYTES_PER_WORD * BYTE_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_shift,
  input  logic [BCNT_W-1:0] i_byte_cnt,
  output logic [BYTE_W-1:0] o_byte,
  output logic              o_last
);
  logic [WORD_W-1:0] sr;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)     sr <= '0;
    else if (i_load)  sr <= i_word;
    else if (i_shift) sr <= {sr[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
  end

  assign o_byte = sr[WORD_W-1 -: BYTE_W];
  assign o_last = (i_byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/mem_dump_sequencer.sv
// Walks DUMP_WORDS debug-port addresses while halted and streams each word to UART TX.
// Define MEM_DUMP_CHECKSUM_EN to append one XOR checksum byte after the last word.
module mem_dump_sequencer
  import debug_pkg::*;
#(
  parameter int BITS_SIZE    = 32,
  parameter int DUMP_WORDS   = 32,
  parameter int ADDR_STRIDE  = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_halted,
  input  logic [BITS_SIZE-1:0] i_mem_dato_debug,
  input  logic                 i_tx_ready,
  output logic [BITS_SIZE-1:0] o_addr_mem_debug,
  output logic [BYTE_W-1:0]    o_tx_byte,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_abort
);
  localparam int WORD_W = BYTES_PER_WORD * BYTE_W;
  localparam int CNT_W  = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DUMP_WORDS - 1);

  dump_state_e       state;
  logic [CNT_W-1:0]  word_cnt;
  logic [BCNT_W-1:0] byte_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              xfer, last_byte, ser_load, ser_shift;
  logic [WORD_W-1:0] ser_word;

  assign xfer      = o_tx_valid & i_tx_ready;
  assign ser_shift = (state == ST_SEND) & xfer;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [BYTE_W-1:0] cksum;
  logic              ck_load;
  // The checksum rides through the serializer as a word whose top byte is the XOR.
  assign ck_load  = ser_shift & last_byte & (word_cnt == LAST_WORD);
  assign ser_load = (state == ST_LATCH) | ck_load;
  assign ser_word = (state == ST_LATCH) ? WORD_W'(i_mem_dato_debug)
                                        : {cksum ^ o_tx_byte, {(WORD_W-BYTE_W){1'b0}}};
`else
  assign ser_load = (state == ST_LATCH);
  assign ser_word = WORD_W'(i_mem_dato_debug);
`endif

  word_serializer #(.WORD_W(WORD_W)) u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (ser_load),
    .i_word     (ser_word),
    .i_shift    (ser_shift),
    .i_byte_cnt (byte_cnt),
    .o_byte     (o_tx_byte),
    .o_last     (last_byte)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state            <= ST_IDLE;
      word_cnt         <= '0;
      byte_cnt         <= '0;
      lat_cnt          <= '0;
      o_addr_mem_debug <= '0;
      o_tx_valid       <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_abort          <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum            <= '0;
`endif
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      // Losing halt cancels the dump from any active state, even mid-byte.
      if (state != ST_IDLE && !i_halted) begin
        state            <= ST_IDLE;
        o_abort          <= 1'b1;
        o_tx_valid       <= 1'b0;
        o_busy           <= 1'b0;
        o_addr_mem_debug <= '0;
      end else begin
        case (state)
          ST_IDLE: if (i_start && i_halted) begin
            state            <= ST_ADDR;
            word_cnt         <= '0;
            o_addr_mem_debug <= '0;
            o_busy           <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
            cksum            <= '0;
`endif
          end
          ST_ADDR: begin
            o_addr_mem_debug <= BITS_SIZE'(word_cnt) * BITS_SIZE'(ADDR_STRIDE);
            lat_cnt          <= LAT_W'(READ_LATENCY);
            state            <= ST_WAIT;
          end
          ST_WAIT: begin
            if (lat_cnt == LAT_W'(1)) state <= ST_LATCH;
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
          ST_LATCH: begin
            byte_cnt   <= '0;
            o_tx_valid <= 1'b1;
            state      <= ST_SEND;
          end
          ST_SEND: if (xfer) begin
            byte_cnt <= byte_cnt + BCNT_W'(1);
`ifdef MEM_DUMP_CHECKSUM_EN
            cksum    <= cksum ^ o_tx_byte;
`endif
            if (last_byte) begin
              if (word_cnt == LAST_WORD) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                state      <= ST_CKSUM;
`else
                o_tx_valid <= 1'b0;
                state      <= ST_FINISH;
                o_done     <= 1'b1;
`endif
              end else begin
                o_tx_valid <= 1'b0;
                word_cnt   <= word_cnt + CNT_W'(1);
                state      <= ST_ADDR;
              end
            end
          end
`ifdef MEM_DUMP_CHECKSUM_EN
          ST_CKSUM: if (xfer) begin
            o_tx_valid <= 1'b0;
            state      <= ST_FINISH;
            o_done     <= 1'b1;
          end
`endif
          ST_FINISH: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mem_dump_sequencer.sv
// Randomized bench for mem_dump_sequencer: byte stream, handshake, abort and reset
// behaviour checked against a word-list model of the dump.
module tb_mem_dump_sequencer;
  localparam int BITS = 32;
  localparam int DW   = 4;
  localparam int STR  = 4;
  localparam int RL   = 2;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int TOTAL = 4 * DW + CK;

  logic            i_clk, i_reset, i_start, i_halted, i_tx_ready;
  logic [BITS-1:0] i_mem_dato_debug, o_addr_mem_debug;
  logic [7:0]      o_tx_byte;
  logic            o_tx_valid, o_busy, o_done, o_abort;

  mem_dump_sequencer #(.BITS_SIZE(BITS), .DUMP_WORDS(DW), .ADDR_STRIDE(STR), .READ_LATENCY(RL)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_halted(i_halted),
    .i_mem_dato_debug(i_mem_dato_debug), .i_tx_ready(i_tx_ready),
    .o_addr_mem_debug(o_addr_mem_debug), .o_tx_byte(o_tx_byte), .o_tx_valid(o_tx_valid),
    .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory with RL cycles from address change to valid read data.
  logic [31:0] mem [DW];
  logic [31:0] rd_pipe [RL];
  always @(posedge i_clk) begin
    rd_pipe[0] <= mem[int'((o_addr_mem_debug / STR) % DW)];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign i_mem_dato_debug = rd_pipe[RL-1];

  // Monitor samples mid-cycle: values seen here are what the next rising edge acts on.
  logic [7:0] got [$];
  int done_cnt = 0, abort_cnt = 0, busy_cyc = 0, stab_err = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;
  always @(negedge i_clk) begin
    #1;
    if (i_reset) begin
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_byte);
      if (o_done)  done_cnt  <= done_cnt + 1;
      if (o_abort) abort_cnt <= abort_cnt + 1;
      if (o_busy)  busy_cyc  <= busy_cyc + 1;
      if (prev_stall && !(o_tx_valid && o_tx_byte == prev_byte)) stab_err <= stab_err + 1;
      prev_stall <= o_tx_valid && !i_tx_ready && i_halted;
      prev_byte  <= o_tx_byte;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: dump is every word MSB byte first, then optionally the XOR of them all.
  function automatic logic [7:0] exp_byte(input int i);
    logic [7:0] x;
    logic [31:0] w;
    if (i < 4 * DW) begin
      w = mem[i / 4];
      return w[31 - 8 * (i % 4) -: 8];
    end
    x = '0;
    for (int k = 0; k < 4 * DW; k++) x ^= exp_byte(k);
    return x;
  endfunction

  task automatic new_mem(input bit fixed);
    for (int i = 0; i < DW; i++) mem[i] = $urandom;
    if (fixed) begin
      mem[0] = 32'h1122_3344;
      mem[1] = 32'hA5A5_0F0F;
    end
  endtask

  task automatic chk_bytes(input int base, input int n, input string tag);
    chk({tag, "_nbytes"}, got.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < got.size()) chk($sformatf("%s_byte%0d", tag, i), got[base+i], exp_byte(i));
  endtask

  task automatic do_dump(input bit rnd, input bit poke, input bit tp, input string tag);
    int base, d0, a0, b0;
    bit fin;
    base = got.size(); d0 = done_cnt; a0 = abort_cnt; b0 = busy_cyc; fin = 0;
    @(negedge i_clk);
    i_halted = 1'b1; i_start = 1'b1; i_tx_ready = 1'b1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (rnd) i_tx_ready = 1'($urandom_range(0, 1));
      // Start requests while busy, including alongside the final transfer, must be ignored.
      if (poke && (cyc == 10 || (got.size() - base == TOTAL - 1 && o_tx_valid))) i_start = 1'b1;
      #2;
      fin = (done_cnt != d0) || (abort_cnt != a0);
    end
    if (!fin) chk({tag, "_timeout"}, 0, 1);
    @(negedge i_clk);
    i_start = 1'b0; i_tx_ready = 1'b1;
    repeat (4) @(negedge i_clk);
    #2;
    chk({tag, "_done"}, done_cnt - d0, 1);
    chk({tag, "_abort"}, abort_cnt - a0, 0);
    chk({tag, "_busy_after"}, o_busy, 0);
    chk({tag, "_last_addr"}, o_addr_mem_debug, (DW - 1) * STR);
    chk_bytes(base, TOTAL, tag);
    if (tp) chk({tag, "_busy_cycles"}, busy_cyc - b0, DW * (6 + RL) + 1 + CK);
    chk({tag, "_stall_stable"}, stab_err, 0);
  endtask

  initial begin
    int base, d0, a0;
    bit armed, dropped, fin, seen;
    i_reset = 1'b1; i_start = 1'b0; i_halted = 1'b0; i_tx_ready = 1'b1;
    new_mem(1);
    #3 i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    #2;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_abort", o_abort, 0);
    chk("rst_addr", o_addr_mem_debug, 0);
    chk("rst_byte", o_tx_byte, 0);
    @(negedge i_clk) i_reset = 1'b1;

    // Start without halt is ignored.
    @(negedge i_clk);
    i_start = 1'b1; i_halted = 1'b0;
    @(negedge i_clk) i_start = 1'b0;
    repeat (6) @(negedge i_clk);
    #2;
    chk("nohalt_busy", o_busy, 0);
    chk("nohalt_bytes", got.size(), 0);

    do_dump(0, 1, 1, "fixed");
    new_mem(0); do_dump(1, 0, 0, "rnd1");
    new_mem(0); do_dump(1, 0, 0, "rnd2");
    new_mem(1); do_dump(1, 1, 0, "rnd3");

    // Halt drops during the read wait of word index 3.
    new_mem(0);
    base = got.size(); d0 = done_cnt; a0 = abort_cnt;
    armed = 0; dropped = 0; fin = 0;
    @(negedge i_clk);
    i_halted = 1'b1; i_start = 1'b1; i_tx_ready = 1'b1;
    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (o_addr_mem_debug == 2 * STR) armed = 1;
      if (armed && !dropped && o_addr_mem_debug == 3 * STR) begin
        i_halted = 1'b0; dropped = 1;
      end
      #2;
      fin = (done_cnt != d0) || (abort_cnt != a0);
    end
    if (!fin) chk("abort_timeout", 0, 1);
    chk("abort_pulse", abort_cnt - a0, 1);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_valid", o_tx_valid, 0);
    chk("abort_busy", o_busy, 0);
    chk("abort_addr", o_addr_mem_debug, 0);
    chk_bytes(base, 12, "abort");
    @(negedge i_clk) i_halted = 1'b1;
    repeat (4) @(negedge i_clk);
    #2;
    chk("abort_stays_idle", o_busy, 0);

    // Reset while a byte is stalled in SEND, then a clean dump from address 0.
    seen = 0;
    @(negedge i_clk);
    i_start = 1'b1; i_tx_ready = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      seen = o_tx_valid;
    end
    if (!seen) chk("midrst_timeout", 0, 1);
    i_reset = 1'b0;
    #1;
    chk("midrst_valid", o_tx_valid, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_addr", o_addr_mem_debug, 0);
    chk("midrst_byte", o_tx_byte, 0);
    @(negedge i_clk);
    i_reset = 1'b1; i_tx_ready = 1'b1;
    new_mem(0);
    do_dump(0, 0, 1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
